// File: rtl/pipelined_ext_adder_pkg.sv
// Shared sizing helpers for the segmented extending adder: stage count and per-stage width.
package pipelined_ext_adder_pkg;

  localparam int STG_IDX_W = 8;
  typedef logic [STG_IDX_W-1:0] stg_idx_t;

  function automatic int num_stages(input int wa, input int seg);
    return (wa + seg - 1) / seg;
  endfunction

  // All segments are SEG wide except the top one, which takes whatever bits remain.
  function automatic int seg_width(input stg_idx_t k, input int wa, input int seg);
    int n;
    n = num_stages(wa, seg);
    return (int'(k) == n - 1) ? (wa - (n - 1) * seg) : seg;
  endfunction

endpackage

// File: rtl/pipelined_ext_adder_if.sv
// Input/output handshake bundle of pipelined_ext_adder; b_signed exists only with PIPELINED_EXT_ADDER_SIGNED_EN.
interface pipelined_ext_adder_if #(
  parameter int WA    = 37,
  parameter int WB    = 23,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WA-1:0]    A;
  logic [WB-1:0]    B;
  logic [TAG_W-1:0] in_tag;
`ifdef PIPELINED_EXT_ADDER_SIGNED_EN
  logic             b_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WA:0]      Sum;
  logic [TAG_W-1:0] out_tag;

  modport master (
`ifdef PIPELINED_EXT_ADDER_SIGNED_EN
    output b_signed,
`endif
    output in_valid, A, B, in_tag, out_ready,
    input  in_ready, out_valid, Sum, out_tag
  );

  modport slave (
`ifdef PIPELINED_EXT_ADDER_SIGNED_EN
    input  b_signed,
`endif
    input  in_valid, A, B, in_tag, out_ready,
    output in_ready, out_valid, Sum, out_tag
  );
endinterface

// File: rtl/pipelined_ext_adder_segment.sv
// One carry segment: SW-bit add with carry-in, sum and carry-out registered under the pipeline enable.
module adder_segment #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum_q,
  output logic          cout_q
);
  logic [SW-1:0] sum_d;
  logic          cout_d;

  always_comb begin
    {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end
endmodule

// File: rtl/pipelined_ext_adder.sv
// Segmented pipelined A + ext(B) with valid/ready and a tag sideband.
// Optional PIPELINED_EXT_ADDER_SIGNED_EN adds b_signed to select sign- or zero-extension of B.
module pipelined_ext_adder
  import pipelined_ext_adder_pkg::*;
#(
  parameter int WA    = 37,
  parameter int WB    = 23,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_ext_adder_if.slave  bus
);
  localparam int NSTG = num_stages(WA, SEG);

  logic             en;
  logic [WA-1:0]    b_ext;
  logic [NSTG-1:0]  vld_d, vld_q;
  logic [TAG_W-1:0] tag_d [NSTG];
  logic [TAG_W-1:0] tag_q [NSTG];
  logic [NSTG-1:0]  cout;
  logic [WA-1:0]    sum_raw;

  // The whole pipe advances together; it only stalls when a result is waiting unaccepted.
  assign en           = !vld_q[NSTG-1] || bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    b_ext          = '0;
    b_ext[WB-1:0]  = bus.B;
`ifdef PIPELINED_EXT_ADDER_SIGNED_EN
    for (int i = WB; i < WA; i++) b_ext[i] = bus.b_signed & bus.B[WB-1];
`endif
  end

  always_comb begin
    vld_d[0] = bus.in_valid;
    tag_d[0] = bus.in_tag;
    for (int k = 1; k < NSTG; k++) begin
      vld_d[k] = vld_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_q <= '0;
    else if (en) vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (en) tag_q <= tag_d;
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int SW  = seg_width(stg_idx_t'(k), WA, SEG);
    localparam int DSK = NSTG - 1 - k;

    logic [SW-1:0] a_op, b_op, seg_sum;
    logic          cin;

    // Operand segment k waits k cycles so it meets the carry rippling up from below.
    if (k == 0) begin : g_direct
      assign a_op = bus.A[LO +: SW];
      assign b_op = b_ext[LO +: SW];
    end else begin : g_skew
      logic [2*SW-1:0] skew_d [k];
      logic [2*SW-1:0] skew_q [k];
      always_comb begin
        skew_d[0] = {bus.A[LO +: SW], b_ext[LO +: SW]};
        for (int j = 1; j < k; j++) skew_d[j] = skew_q[j-1];
      end
      always_ff @(posedge clk) begin
        if (en) skew_q <= skew_d;
      end
      assign {a_op, b_op} = skew_q[k-1];
    end

    if (k == 0) begin : g_cin0
      assign cin = 1'b0;
    end else begin : g_cinr
      assign cin = cout[k-1];
    end

    adder_segment #(.SW(SW)) u_seg (
      .clk    (clk),
      .en     (en),
      .a      (a_op),
      .b      (b_op),
      .cin    (cin),
      .sum_q  (seg_sum),
      .cout_q (cout[k])
    );

    // Lower result segments finish early and are held back to line up with the top one.
    if (DSK == 0) begin : g_nodsk
      assign sum_raw[LO +: SW] = seg_sum;
    end else begin : g_dsk
      logic [SW-1:0] dsk_d [DSK];
      logic [SW-1:0] dsk_q [DSK];
      always_comb begin
        dsk_d[0] = seg_sum;
        for (int j = 1; j < DSK; j++) dsk_d[j] = dsk_q[j-1];
      end
      always_ff @(posedge clk) begin
        if (en) dsk_q <= dsk_d;
      end
      assign sum_raw[LO +: SW] = dsk_q[DSK-1];
    end
  end

  // Datapath flops carry no reset, so outputs read as zero whenever no result is presented.
  assign bus.out_valid = vld_q[NSTG-1];
  assign bus.Sum       = vld_q[NSTG-1] ? {cout[NSTG-1], sum_raw} : '0;
  assign bus.out_tag   = vld_q[NSTG-1] ? tag_q[NSTG-1] : '0;

endmodule

// File: tb/tb_pipelined_ext_adder.sv
// Directed/random bench for pipelined_ext_adder with a result scoreboard (WA=37, WB=23, SEG=8).
module tb_pipelined_ext_adder;
  localparam int WA = 37, WB = 23, SEG = 8, TAG_W = 4;

  typedef struct {
    logic [WA:0]      sum;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_ext_adder_if #(.WA(WA), .WB(WB), .TAG_W(TAG_W)) bus ();
  pipelined_ext_adder #(.WA(WA), .WB(WB), .SEG(SEG), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, acc_cyc = 0, out_cnt = 0, last_out_cyc = 0;
  logic cur_sgn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [WA:0] model(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                         input logic s);
    logic [WA-1:0] bx;
    bx = '0;
    bx[WB-1:0] = b;
    for (int i = WB; i < WA; i++) bx[i] = s & b[WB-1];
    return {1'b0, a} + {1'b0, bx};
  endfunction

  // Output side: every presented-and-accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(bus.out_valid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("sum", 64'(bus.Sum), 64'(mon_e.sum));
        check("tag", 64'(bus.out_tag), 64'(mon_e.tag));
        out_cnt++;
        last_out_cyc = cyc;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b,
                      input logic [TAG_W-1:0] t, input logic [WA:0] exp);
    bus.A = a;
    bus.B = b;
    bus.in_tag = t;
    bus.in_valid = 1'b1;
`ifdef PIPELINED_EXT_ADDER_SIGNED_EN
    bus.b_signed = cur_sgn;
`endif
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{exp, t});
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.out_valid); i++) @(negedge clk);
    check(nm, 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] t);
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    ra[31:0]    = $urandom();
    ra[WA-1:32] = (WA-32)'($urandom());
    rb          = WB'($urandom());
    send(ra, rb, t, model(ra, rb, cur_sgn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, acc0, stale;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
`ifdef PIPELINED_EXT_ADDER_SIGNED_EN
    bus.b_signed  = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_sum",       64'(bus.Sum),       64'(0));
    check("rst_tag",       64'(bus.out_tag),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full carry ripple across every segment, plus latency
    send(37'h1F_FFFF_FFFF, 23'h1, 4'h1, 38'h20_0000_0000);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("latency", 64'(cyc - acc_cyc), 64'(5));
    drain("t1_drain");

    send(37'h1F_FFFF_FFFF, 23'h7F_FFFF, 4'h2, 38'h20_007F_FFFE);
    bus.in_valid = 1'b0;
    drain("t2_drain");

    // Back-to-back random stream
    cnt0 = out_cnt;
    acc0 = 0;
    for (int i = 0; i < 20; i++) begin
      send_rand(TAG_W'(i));
      if (i == 0) acc0 = acc_cyc;
    end
    bus.in_valid = 1'b0;
    drain("t3_drain");
    check("t3_count", 64'(out_cnt - cnt0), 64'(20));
    check("t3_span",  64'(last_out_cyc - acc0), 64'(24));

    // Stall with a full pipe
    cnt0 = out_cnt;
    for (int i = 0; i < 5; i++) send_rand(TAG_W'(8 + i));
    bus.out_ready = 1'b0;
    bus.A = 37'h0A_5A5A_5A5A;
    bus.B = 23'h12_3456;
    bus.in_tag = 4'hD;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_in_ready",  64'(bus.in_ready),  64'(0));
      check("stall_out_valid", 64'(bus.out_valid), 64'(1));
      check("stall_sum",       64'(bus.Sum),       64'(sb[0].sum));
      check("stall_tag",       64'(bus.out_tag),   64'(sb[0].tag));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(37'h0A_5A5A_5A5A, 23'h12_3456, 4'hD, model(37'h0A_5A5A_5A5A, 23'h12_3456, cur_sgn));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    send_rand(4'hE);
    bus.in_valid = 1'b0;
    drain("t4_drain");
    check("t4_count", 64'(out_cnt - cnt0), 64'(7));

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) send_rand(TAG_W'(3 + i));
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("t5_pre_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid",    64'(bus.out_valid), 64'(0));
    check("t5_rst_sum",      64'(bus.Sum),       64'(0));
    check("t5_rst_in_ready", 64'(bus.in_ready),  64'(1));
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("t5_stale", 64'(stale), 64'(0));
    @(posedge clk);
    #1;
    send(37'h00_0000_00FF, 23'h01, 4'h7, 38'h00_0000_0100);
    bus.in_valid = 1'b0;
    drain("t5_drain");

`ifdef PIPELINED_EXT_ADDER_SIGNED_EN
    cur_sgn = 1'b1;
    send(37'h10, 23'h7F_FFFF, 4'h3, 38'h20_0000_000F);
    cur_sgn = 1'b0;
    send(37'h10, 23'h7F_FFFF, 4'h4, 38'h00_0080_000F);
    bus.in_valid = 1'b0;
    drain("t6_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
